hazard_ctrl_v2: RTL and testbench

- Pipeline hazard and control unit for the 5-stage MIPS core (F/D/E/M/W); successor to the current combinational hazard unit.
- Adds parametrised register-address width, exception vectors and branch-forwarding mode.
- Adds a sequenced divider handshake FSM, a held exception redirect with fetch back-pressure, and saturating stall-cause counters.
- Sits between the datapath stages, the divider, CP0 and the fetch/memory bridges.

---
 rtl/hazard_ctrl_v2.sv | 205 ++++++++++++++++++++
 tb/tb_hazard_ctrl_v2.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl_v2.sv
// Hazard/control unit for the 5-stage MIPS pipeline: forwarding selects, stall/flush
// generation, divider handshake, held exception redirect and saturating stall counters.

module hazard_ctrl_v2_sat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                cnt <= '0;
    else if (inc && cnt != '1)  cnt <= cnt + 1'b1;
  end
endmodule

module hazard_ctrl_v2 #(
  parameter int          REG_AW    = 5,
  parameter logic [31:0] EXC_VEC   = 32'hBFC00380,
  parameter logic [31:0] ERET_CODE = 32'h0000000E,
  parameter bit          BR_E_FWD  = 1'b1,
  parameter int          CNT_W     = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [REG_AW-1:0] rsD,
  input  logic [REG_AW-1:0] rtD,
  input  logic              brD,
  input  logic [REG_AW-1:0] rsE,
  input  logic [REG_AW-1:0] rtE,
  input  logic [REG_AW-1:0] writeregE,
  input  logic [REG_AW-1:0] writeregM,
  input  logic [REG_AW-1:0] writeregW,
  input  logic              regwriteE,
  input  logic              regwriteM,
  input  logic              regwriteW,
  input  logic              memtoregE,
  input  logic              memtoregM,
  input  logic [1:0]        hilo_weE,
  input  logic [1:0]        hilo_weM,
  input  logic [1:0]        hilo_weW,
  input  logic              divE,
  input  logic              div_ready,
  output logic              div_start,
  output logic              div_cancel,
  input  logic [31:0]       excepttypeM,
  input  logic [31:0]       cp0_epcM,
  input  logic              stallreq_if,
  input  logic              stallreq_mem,
  output logic [1:0]        forwardaD,
  output logic [1:0]        forwardbD,
  output logic [1:0]        forwardaE,
  output logic [1:0]        forwardbE,
  output logic [1:0]        forwardhiloE,
  output logic              stallF,
  output logic              stallD,
  output logic              stallE,
  output logic              stallM,
  output logic              flushF,
  output logic              flushD,
  output logic              flushE,
  output logic              flushM,
  output logic              flushW,
  output logic              redirect_valid,
  output logic [31:0]       redirect_pc,
  output logic [CNT_W-1:0]  cnt_load,
  output logic [CNT_W-1:0]  cnt_div,
  output logic [CNT_W-1:0]  cnt_mem
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0][REG_AW-1:0] src_d, src_e;
  logic [1:0][1:0]        fwd_d, fwd_e;
  logic                   except;
  logic                   d_match_e, d_match_m;
  logic                   load_stall, br_stall, div_stall, stall_any, stall_e_raw;
  logic [1:0]             div_st, div_st_nxt;
  logic                   start_c, cancel_c;
  logic                   rv_q;
  logic [31:0]            rpc_q;
  logic [2:0]             cnt_inc;
  logic [2:0][CNT_W-1:0]  cnt_q;
  logic [1:0]             fwd_hilo;

  assign src_d = {rtD, rsD};
  assign src_e = {rtE, rsE};

  // D-stage compare sources: E>M>W; E-stage ALU sources: M>W. $0 never forwards.
  for (genvar g = 0; g < 2; g++) begin : g_fwd
    always_comb begin
      fwd_d[g] = 2'b00;
      if (src_d[g] != '0) begin
        if (regwriteE && writeregE == src_d[g])      fwd_d[g] = 2'b01;
        else if (regwriteM && writeregM == src_d[g]) fwd_d[g] = 2'b10;
        else if (regwriteW && writeregW == src_d[g]) fwd_d[g] = 2'b11;
      end
    end
    always_comb begin
      fwd_e[g] = 2'b00;
      if (src_e[g] != '0) begin
        if (regwriteM && writeregM == src_e[g])      fwd_e[g] = 2'b10;
        else if (regwriteW && writeregW == src_e[g]) fwd_e[g] = 2'b01;
      end
    end
  end

  always_comb begin
    fwd_hilo = 2'b00;
    if (hilo_weE == 2'b00) begin
      if (hilo_weM != 2'b00)      fwd_hilo = 2'b01;
      else if (hilo_weW != 2'b00) fwd_hilo = 2'b10;
    end
  end

  assign except     = excepttypeM != 32'd0;
  assign d_match_e  = writeregE != '0 && (writeregE == rsD || writeregE == rtD);
  assign d_match_m  = writeregM == rsD || writeregM == rtD;
  assign load_stall = memtoregE && regwriteE && d_match_e;
  assign br_stall   = brD && ((memtoregM && d_match_m) ||
                              (!BR_E_FWD && regwriteE && d_match_e));

  // Divider handshake; DONE releases E for exactly one cycle.
  always_comb begin
    div_st_nxt = div_st;
    start_c    = 1'b0;
    cancel_c   = 1'b0;
    case (div_st)
      S_IDLE: if (divE && !except) begin
        div_st_nxt = S_BUSY;
        start_c    = 1'b1;
      end
      S_BUSY: begin
        if (except) begin
          div_st_nxt = S_IDLE;
          cancel_c   = 1'b1;
        end else if (div_ready) begin
          div_st_nxt = S_DONE;
        end
      end
      S_DONE:  div_st_nxt = S_IDLE;
      default: div_st_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) div_st <= S_IDLE;
    else         div_st <= div_st_nxt;
  end

  assign div_stall   = (div_st == S_IDLE && divE) || div_st == S_BUSY;
  assign stall_any   = load_stall || br_stall || div_stall || stallreq_if || stallreq_mem;
  assign stall_e_raw = div_stall || stallreq_mem;

  // Redirect is held until fetch accepts it; a newer exception retargets it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rv_q  <= 1'b0;
      rpc_q <= 32'd0;
    end else if (except) begin
      rv_q  <= 1'b1;
      rpc_q <= (excepttypeM == ERET_CODE) ? cp0_epcM : EXC_VEC;
    end else if (rv_q && !stallreq_if) begin
      rv_q  <= 1'b0;
    end
  end

  assign cnt_inc = {stallreq_mem, div_stall, load_stall | br_stall};
  for (genvar g = 0; g < 3; g++) begin : g_cnt
    hazard_ctrl_v2_sat_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk    (clk),
      .resetn (resetn),
      .inc    (cnt_inc[g]),
      .cnt    (cnt_q[g])
    );
  end

  // Combinational outputs are gated so the whole block reads zero during reset.
  assign forwardaD    = resetn ? fwd_d[0] : 2'b00;
  assign forwardbD    = resetn ? fwd_d[1] : 2'b00;
  assign forwardaE    = resetn ? fwd_e[0] : 2'b00;
  assign forwardbE    = resetn ? fwd_e[1] : 2'b00;
  assign forwardhiloE = resetn ? fwd_hilo : 2'b00;
  assign div_start    = resetn && start_c;
  assign div_cancel   = resetn && cancel_c;

  assign stallF = resetn && !except && stall_any;
  assign stallD = resetn && !except && stall_any;
  assign stallE = resetn && !except && stall_e_raw;
  assign stallM = resetn && !except && stallreq_mem;

  assign flushF = resetn && (except || rv_q);
  assign flushD = resetn && (except || rv_q);
  assign flushE = resetn && (((load_stall || br_stall) && !stall_e_raw) || except);
  assign flushM = resetn && except;
  assign flushW = resetn && (except || stallreq_mem);

  assign redirect_valid = rv_q;
  assign redirect_pc    = rpc_q;
  assign cnt_load       = cnt_q[0];
  assign cnt_div        = cnt_q[1];
  assign cnt_mem        = cnt_q[2];
endmodule

// File: tb/tb_hazard_ctrl_v2.sv
// Directed bench for hazard_ctrl_v2: two instances (branch-forward on / off with narrow
// counters) checked every cycle against a rule-level model plus literal spot checks.

module tb_hazard_ctrl_v2;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic [4:0]  rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic        brD, regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
  logic [1:0]  hilo_weE, hilo_weM, hilo_weW;
  logic        divE, div_ready, stallreq_if, stallreq_mem;
  logic [31:0] excepttypeM, cp0_epcM;

  typedef struct packed {
    logic ds, dc;
    logic [1:0] fad, fbd, fae, fbe, fh;
    logic sf, sd, se, sm, ff, fd, fe, fm, fw, rv;
    logic [31:0] rpc;
    logic [15:0] cl, cd, cm;
  } outs_t;

  logic        ds_a, dc_a, sf_a, sd_a, se_a, sm_a, ff_a, fd_a, fe_a, fm_a, fw_a, rv_a;
  logic [1:0]  fad_a, fbd_a, fae_a, fbe_a, fh_a;
  logic [31:0] rpc_a;
  logic [15:0] cl_a, cd_a, cm_a;
  logic        ds_b, dc_b, sf_b, sd_b, se_b, sm_b, ff_b, fd_b, fe_b, fm_b, fw_b, rv_b;
  logic [1:0]  fad_b, fbd_b, fae_b, fbe_b, fh_b;
  logic [31:0] rpc_b;
  logic [3:0]  cl_b, cd_b, cm_b;
  outs_t o_a, o_b;

  assign o_a = {ds_a, dc_a, fad_a, fbd_a, fae_a, fbe_a, fh_a, sf_a, sd_a, se_a, sm_a,
                ff_a, fd_a, fe_a, fm_a, fw_a, rv_a, rpc_a, cl_a, cd_a, cm_a};
  assign o_b = {ds_b, dc_b, fad_b, fbd_b, fae_b, fbe_b, fh_b, sf_b, sd_b, se_b, sm_b,
                ff_b, fd_b, fe_b, fm_b, fw_b, rv_b, rpc_b,
                12'd0, cl_b, 12'd0, cd_b, 12'd0, cm_b};

  hazard_ctrl_v2 dut_a (
    .clk(clk), .resetn(resetn), .rsD(rsD), .rtD(rtD), .brD(brD), .rsE(rsE), .rtE(rtE),
    .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
    .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .memtoregE(memtoregE), .memtoregM(memtoregM),
    .hilo_weE(hilo_weE), .hilo_weM(hilo_weM), .hilo_weW(hilo_weW),
    .divE(divE), .div_ready(div_ready), .div_start(ds_a), .div_cancel(dc_a),
    .excepttypeM(excepttypeM), .cp0_epcM(cp0_epcM),
    .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem),
    .forwardaD(fad_a), .forwardbD(fbd_a), .forwardaE(fae_a), .forwardbE(fbe_a),
    .forwardhiloE(fh_a), .stallF(sf_a), .stallD(sd_a), .stallE(se_a), .stallM(sm_a),
    .flushF(ff_a), .flushD(fd_a), .flushE(fe_a), .flushM(fm_a), .flushW(fw_a),
    .redirect_valid(rv_a), .redirect_pc(rpc_a),
    .cnt_load(cl_a), .cnt_div(cd_a), .cnt_mem(cm_a));

  hazard_ctrl_v2 #(.BR_E_FWD(1'b0), .CNT_W(4)) dut_b (
    .clk(clk), .resetn(resetn), .rsD(rsD), .rtD(rtD), .brD(brD), .rsE(rsE), .rtE(rtE),
    .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
    .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .memtoregE(memtoregE), .memtoregM(memtoregM),
    .hilo_weE(hilo_weE), .hilo_weM(hilo_weM), .hilo_weW(hilo_weW),
    .divE(divE), .div_ready(div_ready), .div_start(ds_b), .div_cancel(dc_b),
    .excepttypeM(excepttypeM), .cp0_epcM(cp0_epcM),
    .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem),
    .forwardaD(fad_b), .forwardbD(fbd_b), .forwardaE(fae_b), .forwardbE(fbe_b),
    .forwardhiloE(fh_b), .stallF(sf_b), .stallD(sd_b), .stallE(se_b), .stallM(sm_b),
    .flushF(ff_b), .flushD(fd_b), .flushE(fe_b), .flushM(fm_b), .flushW(fw_b),
    .redirect_valid(rv_b), .redirect_pc(rpc_b),
    .cnt_load(cl_b), .cnt_div(cd_b), .cnt_mem(cm_b));

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b1;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- model: rule-level, raw counts saturated on read ----------------
  int          mphase;   // 0 no divide outstanding, 1 waiting on divider, 2 result cycle
  bit          mrv;
  logic [31:0] mpc;
  int          mcl[2];
  int          mcd, mcm;

  function automatic bit exc_now();
    return excepttypeM != 0;
  endfunction
  function automatic bit d_hit_e();
    return writeregE != 0 && (writeregE == rsD || writeregE == rtD);
  endfunction
  function automatic bit ld_now();
    return memtoregE && regwriteE && d_hit_e();
  endfunction
  function automatic bit br_now(int k);
    return brD && ((memtoregM && (writeregM == rsD || writeregM == rtD)) ||
                   (k == 0 && regwriteE && d_hit_e()));
  endfunction
  function automatic bit dv_now();
    return (mphase == 0 && divE) || mphase == 1;
  endfunction
  function automatic logic [1:0] efd(logic [4:0] s);
    if (s == 0) return 2'd0;
    if (regwriteE && writeregE == s) return 2'd1;
    if (regwriteM && writeregM == s) return 2'd2;
    if (regwriteW && writeregW == s) return 2'd3;
    return 2'd0;
  endfunction
  function automatic logic [1:0] efe(logic [4:0] s);
    if (s == 0) return 2'd0;
    if (regwriteM && writeregM == s) return 2'd2;
    if (regwriteW && writeregW == s) return 2'd1;
    return 2'd0;
  endfunction
  function automatic logic [15:0] sat(int raw, int k);
    int mx;
    mx = (k == 1) ? 65535 : 15;
    return (raw > mx) ? 16'(mx) : 16'(raw);
  endfunction

  function automatic outs_t expect_outs(int k);
    outs_t x;
    bit e, lb, st, dv;
    x = '0;
    if (!resetn) return x;
    e  = exc_now();
    lb = ld_now() || br_now(k);
    dv = dv_now();
    st = lb || dv || stallreq_if || stallreq_mem;
    x.ds  = (mphase == 0) && divE && !e;
    x.dc  = (mphase == 1) && e;
    x.fad = efd(rsD);
    x.fbd = efd(rtD);
    x.fae = efe(rsE);
    x.fbe = efe(rtE);
    if (hilo_weE == 0 && hilo_weM != 0)      x.fh = 2'd1;
    else if (hilo_weE == 0 && hilo_weW != 0) x.fh = 2'd2;
    x.sf  = !e && st;
    x.sd  = !e && st;
    x.se  = !e && (dv || stallreq_mem);
    x.sm  = !e && stallreq_mem;
    x.ff  = e || mrv;
    x.fd  = e || mrv;
    x.fe  = (lb && !(dv || stallreq_mem)) || e;
    x.fm  = e;
    x.fw  = e || stallreq_mem;
    x.rv  = mrv;
    x.rpc = mpc;
    x.cl  = sat(mcl[k], k);
    x.cd  = sat(mcd, k);
    x.cm  = sat(mcm, k);
    return x;
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mphase <= 0; mrv <= 1'b0; mpc <= 32'd0;
      mcl[0] <= 0; mcl[1] <= 0; mcd <= 0; mcm <= 0;
    end else begin
      if (mphase == 0 && divE && !exc_now()) mphase <= 1;
      else if (mphase == 1 && exc_now())     mphase <= 0;
      else if (mphase == 1 && div_ready)     mphase <= 2;
      else if (mphase == 2)                  mphase <= 0;
      if (exc_now()) begin
        mrv <= 1'b1;
        mpc <= (excepttypeM == 32'hE) ? cp0_epcM : 32'hBFC00380;
      end else if (mrv && !stallreq_if) mrv <= 1'b0;
      mcl[0] <= mcl[0] + int'(ld_now() || br_now(0));
      mcl[1] <= mcl[1] + int'(ld_now() || br_now(1));
      mcd    <= mcd + int'(dv_now());
      mcm    <= mcm + int'(stallreq_mem);
    end
  end

  task automatic cmp_outs(string t, outs_t a, outs_t x);
    chk({t, ".div_start"}, 32'(a.ds), 32'(x.ds));
    chk({t, ".div_cancel"}, 32'(a.dc), 32'(x.dc));
    chk({t, ".forwardaD"}, 32'(a.fad), 32'(x.fad));
    chk({t, ".forwardbD"}, 32'(a.fbd), 32'(x.fbd));
    chk({t, ".forwardaE"}, 32'(a.fae), 32'(x.fae));
    chk({t, ".forwardbE"}, 32'(a.fbe), 32'(x.fbe));
    chk({t, ".forwardhiloE"}, 32'(a.fh), 32'(x.fh));
    chk({t, ".stalls"}, 32'({a.sf, a.sd, a.se, a.sm}), 32'({x.sf, x.sd, x.se, x.sm}));
    chk({t, ".flushes"}, 32'({a.ff, a.fd, a.fe, a.fm, a.fw}),
        32'({x.ff, x.fd, x.fe, x.fm, x.fw}));
    chk({t, ".redirect_valid"}, 32'(a.rv), 32'(x.rv));
    chk({t, ".redirect_pc"}, a.rpc, x.rpc);
    chk({t, ".cnt_load"}, 32'(a.cl), 32'(x.cl));
    chk({t, ".cnt_div"}, 32'(a.cd), 32'(x.cd));
    chk({t, ".cnt_mem"}, 32'(a.cm), 32'(x.cm));
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp_outs("a", o_a, expect_outs(1));
      cmp_outs("b", o_b, expect_outs(0));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic clr();
    rsD = 0; rtD = 0; rsE = 0; rtE = 0; brD = 0;
    writeregE = 0; writeregM = 0; writeregW = 0;
    regwriteE = 0; regwriteM = 0; regwriteW = 0; memtoregE = 0; memtoregM = 0;
    hilo_weE = 0; hilo_weM = 0; hilo_weW = 0;
    divE = 0; div_ready = 0; excepttypeM = 0; cp0_epcM = 0;
    stallreq_if = 0; stallreq_mem = 0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
    clr();
  endtask

  initial begin
    clr();
    #2;
    chk("rst_stallF", 32'(sf_a), 0);
    chk("rst_cnt_load", 32'(cl_a), 0);
    nxt(); nxt();
    resetn = 1'b1;

    // load-use
    nxt();
    memtoregE = 1; regwriteE = 1; writeregE = 8; rsD = 8;
    #1;
    chk("lu_stallFD", 32'({sf_a, sd_a}), 32'b11);
    chk("lu_flushE", 32'(fe_a), 1);
    nxt();
    memtoregM = 1; regwriteM = 1; writeregM = 8; rsE = 8;
    #1;
    chk("lu_fwdaE", 32'(fae_a), 32'b10);
    chk("lu_cnt_load", 32'(cl_a), 1);

    // branch compare in D against an E-stage producer
    nxt();
    brD = 1; rsD = 4; regwriteE = 1; writeregE = 4;
    #1;
    chk("br_nofwd_stallD", 32'(sd_b), 1);
    chk("br_fwd_stallD", 32'(sd_a), 0);
    chk("br_fwd_fwdaD", 32'(fad_a), 32'b01);
    nxt();
    brD = 1; rtD = 9; memtoregM = 1; regwriteM = 1; writeregM = 9;
    #1;
    chk("br_loadM_stallD", 32'(sd_a), 1);
    nxt();
    regwriteW = 1; writeregW = 3; rsE = 3; rtE = 0; hilo_weM = 2'b01;
    #1;
    chk("fwd_W_aE", 32'(fae_a), 32'b01);
    chk("fwd_hilo_M", 32'(fh_a), 32'b01);
    nxt();
    regwriteM = 1; writeregM = 3; regwriteW = 1; writeregW = 3; rtE = 3;
    hilo_weE = 2'b01; hilo_weW = 2'b10;
    #1;
    chk("fwd_MoverW_bE", 32'(fbe_a), 32'b10);
    chk("fwd_hilo_Ebusy", 32'(fh_a), 32'b00);

    // divide: start + 5 busy cycles, then one released cycle
    nxt();
    divE = 1;
    #1;
    chk("div_start", 32'({ds_a, se_a}), 32'b11);
    for (int i = 1; i <= 5; i++) begin
      nxt();
      divE = 1; div_ready = (i == 5);
      #1;
      chk("div_busy", 32'({ds_a, se_a}), 32'b01);
    end
    nxt();
    divE = 1;
    #1;
    chk("div_done_stallE", 32'(se_a), 0);
    chk("div_cnt", 32'(cd_a), 6);
    nxt();

    // exception cancels an outstanding divide
    nxt(); divE = 1;
    nxt(); divE = 1;
    nxt(); divE = 1; excepttypeM = 32'h4;
    #1;
    chk("cx_cancel", 32'(dc_a), 1);
    chk("cx_flushes", 32'({ff_a, fd_a, fe_a, fm_a, fw_a}), 32'b11111);
    chk("cx_stallE", 32'(se_a), 0);
    nxt();
    #1;
    chk("cx_rpc", rpc_a, 32'hBFC00380);
    chk("cx_rv", 32'(rv_a), 1);
    nxt();
    #1;
    chk("cx_rv_clr", 32'(rv_a), 0);

    // ERET with fetch back-pressure
    nxt();
    excepttypeM = 32'hE; cp0_epcM = 32'h80001234;
    #1;
    chk("eret_flushF0", 32'(ff_a), 1);
    for (int i = 1; i <= 4; i++) begin
      nxt();
      stallreq_if = (i <= 3);
      #1;
      chk("eret_rv_held", 32'({rv_a, ff_a}), 32'b11);
      chk("eret_rpc", rpc_a, 32'h80001234);
    end
    nxt();
    #1;
    chk("eret_rv_clr", 32'(rv_a), 0);

    // latest exception wins while a redirect is pending
    nxt(); excepttypeM = 32'hE; cp0_epcM = 32'h80001234;
    nxt(); stallreq_if = 1; excepttypeM = 32'h8;
    nxt();
    #1;
    chk("late_rpc", rpc_a, 32'hBFC00380);
    nxt();

    // counter saturation on the 4-bit instance
    for (int i = 0; i < 20; i++) begin
      nxt();
      stallreq_mem = 1;
    end
    nxt();
    #1;
    chk("sat_cnt_mem_b", 32'(cm_b), 15);
    chk("sat_cnt_mem_a", 32'(cm_a), 20);

    // asynchronous reset in the middle of a divide
    nxt(); divE = 1;
    nxt(); divE = 1;
    #1;
    chk("ar_busy", 32'(se_a), 1);
    #1;
    resetn = 1'b0;
    #1;
    chk("ar_a_zero", 32'(o_a != '0), 0);
    chk("ar_b_zero", 32'(o_b != '0), 0);
    chk("ar_rpc", rpc_a, 0);
    nxt();
    resetn = 1'b1;
    #1;
    chk("ar_idle", 32'({se_a, ds_a}), 0);
    nxt(); nxt();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
